dds_cmd_ctrl: RTL
=================

# dds_cmd_ctrl

Command sequencer between the multi-byte UART frame receiver and the DDS channel configuration registers. It latches each validated frame payload, decodes the function code, and issues the resulting register writes over a valid/ready port. It then reports a status byte to the UART transmitter over a start/done handshake. Frames arriving while a command is in progress are dropped and counted.

## Interface
- NUM_CH, 2: number of DDS channels (1..16).
- TX_TIMEOUT, 50_000: sys_clk cycles to wait for tx_done before abandoning the response.
- sys_clk  in  1  system clock; single clock domain.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- recv_done  in  1  one-cycle pulse: frame passed header/tail/CRC checks; rx_byte0..10 valid that cycle.
- crc_fail  in  1  one-cycle pulse: frame header/tail correct, CRC mismatch.
- rx_byte0..rx_byte10  in  8 each  payload: byte0 func, byte1 channel, bytes2-5 freq word (MSB first), bytes6-7 phase, bytes8-9 amplitude, byte10 wave select.
- cfg_valid  out  1  register write request; held until accepted.
- cfg_ready  in  1  write accepted when cfg_valid && cfg_ready.
- cfg_ch  out  4  target channel.
- cfg_addr  out  2  0 freq, 1 phase, 2 amp, 3 wave.
- cfg_wdata  out  32  zero-extended write data.
- ch_en  out  NUM_CH  per-channel output enable.
- tx_start  out  1  one-cycle pulse, tx_data valid that cycle.
- tx_data  out  8  response byte.
- tx_done  in  1  one-cycle pulse, byte transmitted.
- busy  out  1  high whenever state != IDLE.
- drop_cnt  out  8  dropped-frame count, saturating at 0xFF.
- tx_to  out  1  sticky: a response timed out; cleared only by reset.

## Operation
- States: IDLE, DECODE, WRITE, RESP, WAIT_TX.
- IDLE: on recv_done, latch all 11 bytes and go to DECODE. On crc_fail, status = 0x04 and go to RESP. recv_done takes priority if both pulse together.
- DECODE: a channel byte >= NUM_CH gives status 0x03 and goes to RESP.
  - func 0x01/0x02/0x03/0x04: one write to addr 0/1/2/3.
  - func 0x05: four writes, addr 0,1,2,3 in order.
  - func 0x10/0x11: set/clear ch_en[ch] and go to RESP, status 0x01.
  - Any other func gives status 0x02 and goes to RESP.
- WRITE: cfg_valid high with stable cfg_ch/cfg_addr/cfg_wdata until handshake. On accept, advance addr or, after the last write, set status 0x01 and go to RESP. No timeout on cfg_ready.
- RESP: pulse tx_start with status byte, then WAIT_TX.
- WAIT_TX: on tx_done, return to IDLE.
  - When the wait counter reaches TX_TIMEOUT-1 without tx_done, set tx_to and return to IDLE.
- recv_done or crc_fail outside IDLE: the frame is ignored and drop_cnt increments (saturating). A simultaneous recv_done and crc_fail counts once.
- Data widths: freq 32 bits, phase and amp 16 bits zero-extended, wave 8 bits zero-extended.

## Timing
- Reset values: cfg_valid 0, cfg_ch 0, cfg_addr 0, cfg_wdata 0, ch_en 0, tx_start 0, tx_data 0x00, busy 0, drop_cnt 0, tx_to 0. State is IDLE.
- recv_done at edge N: busy high from N+1 (DECODE). cfg_valid first high at N+2.
- Single write with cfg_ready tied high: accepted at N+2, tx_start at N+3.
- Func 0x05 with cfg_ready high: accepts at N+2..N+5, tx_start at N+6.
- Enable/disable (0x10/0x11) or DECODE error: ch_en updates at N+2, tx_start at N+2.
- crc_fail at N: tx_start at N+1.
- tx_done in the same cycle as the timeout compare counts as success (tx_to stays 0).
- Return to IDLE on the edge after tx_done. A frame arriving in that same cycle is dropped.
- Reset mid-operation: immediate return to reset values. Any in-flight write is abandoned with cfg_valid low.

## Configuration
- DDS_CMD_ECHO_EN defined: each response is two bytes, status then latched func byte (0x00 for crc_fail).
  - The second tx_start comes one cycle after the first tx_done. The timeout restarts per byte.
- Not defined: single status byte only.

## Structure
- Shared package dds_cmd_pkg holds:
  - function-code constants (FN_SET_FREQ..FN_CH_OFF),
  - status constants (ST_OK 0x01, ST_BAD_FN 0x02, ST_BAD_CH 0x03, ST_CRC 0x04),
  - cfg_addr constants,
  - the state enum.
- Sub-module dds_cmd_resp owns the RESP/WAIT_TX handshake, timeout counter and echo sequencing. The top-level FSM only hands it status/func and waits for its idle.

## Test plan
- Func 0x01, ch 1, freq 0x12345678, cfg_ready high -> one write at N+2: ch 1, addr 0, wdata 0x12345678. tx_start at N+3 with 0x01.
- Func 0x05, ch 0, cfg_ready low 3 cycles per write -> four writes addr 0..3, each held stable while stalled. Status 0x01 after the fourth accept.
- Func 0x7F -> no cfg_valid, tx_data 0x02. Ch 5 with NUM_CH=2 -> tx_data 0x03. Func 0x10 ch 1 -> ch_en 2'b10.
- crc_fail pulse -> tx_data 0x04. With DDS_CMD_ECHO_EN: second byte 0x00 after tx_done.
- recv_done during WRITE, repeated 300 times -> drop_cnt saturates at 0xFF and the in-progress command completes intact.
- tx_done never returned -> tx_to set exactly TX_TIMEOUT cycles after tx_start, busy falls. Reset asserted during WRITE -> all outputs at reset values immediately.

Source files
------------

// File: rtl/dds_cmd_pkg.sv
// dds_cmd_pkg: shared constants and types for the DDS command sequencer.
//   - function codes carried in payload byte 0
//   - status codes returned to the UART transmitter
//   - cfg_addr register selects
//   - top-level sequencer state enum
//   - cfg_word(): zero-extended write data for a given register select
package dds_cmd_pkg;

   localparam logic [7:0] FN_SET_FREQ  = 8'h01;
   localparam logic [7:0] FN_SET_PHASE = 8'h02;
   localparam logic [7:0] FN_SET_AMP   = 8'h03;
   localparam logic [7:0] FN_SET_WAVE  = 8'h04;
   localparam logic [7:0] FN_SET_ALL   = 8'h05;
   localparam logic [7:0] FN_CH_ON     = 8'h10;
   localparam logic [7:0] FN_CH_OFF    = 8'h11;

   localparam logic [7:0] ST_OK     = 8'h01;
   localparam logic [7:0] ST_BAD_FN = 8'h02;
   localparam logic [7:0] ST_BAD_CH = 8'h03;
   localparam logic [7:0] ST_CRC    = 8'h04;

   localparam logic [1:0] ADDR_FREQ  = 2'd0;
   localparam logic [1:0] ADDR_PHASE = 2'd1;
   localparam logic [1:0] ADDR_AMP   = 2'd2;
   localparam logic [1:0] ADDR_WAVE  = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      WRITE,
      RESP,
      WAIT_TX
   } state_t;

   function automatic logic [31:0] cfg_word(input logic [1:0]  addr,
                                            input logic [31:0] freq,
                                            input logic [15:0] phase,
                                            input logic [15:0] amp,
                                            input logic [7:0]  wave);
      logic [31:0] word;
      case (addr)
         ADDR_FREQ:  word = freq;
         ADDR_PHASE: word = {16'h0000, phase};
         ADDR_AMP:   word = {16'h0000, amp};
         default:    word = {24'h00_0000, wave};
      endcase
      return word;
   endfunction

endpackage

// File: rtl/dds_cmd_resp.sv
// dds_cmd_resp: response handshake towards the UART transmitter.
// A go pulse launches tx_start with the status byte, then waits for tx_done.
// The wait timer is a down-counter loaded with TX_TIMEOUT-1 on every launch;
// reaching zero without tx_done abandons the response and sets sticky tx_to.
// A tx_done on the terminal-count cycle still counts as success.
// Optional build macro DDS_CMD_ECHO_EN: a second byte (the func byte captured
// at go) follows one cycle after the first tx_done, with its own timeout.
// Ports:
//   sys_clk, sys_rst_n  clock, async active-low reset
//   go                  launch a response this cycle
//   status, func        response bytes, sampled on go
//   tx_done             byte transmitted
//   tx_start, tx_data   one-cycle launch pulse and byte
//   tx_to               sticky timeout flag
//   fin                 combinational: response completes at this edge
module dds_cmd_resp #(
   parameter int TX_TIMEOUT = 50_000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       go,
   input  logic [7:0] status,
   input  logic [7:0] func,
   input  logic       tx_done,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       tx_to,
   output logic       fin
);

   localparam int CW = (TX_TIMEOUT > 2) ? $clog2(TX_TIMEOUT) : 1;
   localparam logic [CW-1:0] TMO_LOAD = CW'(TX_TIMEOUT - 1);

   logic          wait_q;
   logic [CW-1:0] wait_cnt;
   logic          tmo;

   assign tmo = (wait_cnt == '0);

`ifdef DDS_CMD_ECHO_EN
   logic [7:0] echo_q;
   logic       second_q;

   assign fin = wait_q && ((tx_done && second_q) || (!tx_done && tmo));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wait_q   <= 1'b0;
         wait_cnt <= '0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         tx_to    <= 1'b0;
         echo_q   <= 8'h00;
         second_q <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         if (!wait_q) begin
            if (go) begin
               tx_start <= 1'b1;
               tx_data  <= status;
               echo_q   <= func;
               second_q <= 1'b0;
               wait_cnt <= TMO_LOAD;
               wait_q   <= 1'b1;
            end
         end else if (tx_done) begin
            if (second_q) begin
               wait_q <= 1'b0;
            end else begin
               tx_start <= 1'b1;
               tx_data  <= echo_q;
               second_q <= 1'b1;
               wait_cnt <= TMO_LOAD;
            end
         end else if (tmo) begin
            tx_to  <= 1'b1;
            wait_q <= 1'b0;
         end else begin
            wait_cnt <= wait_cnt - 1'b1;
         end
      end
   end
`else
   logic unused_func;
   assign unused_func = ^func;

   assign fin = wait_q && (tx_done || tmo);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wait_q   <= 1'b0;
         wait_cnt <= '0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         tx_to    <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         if (!wait_q) begin
            if (go) begin
               tx_start <= 1'b1;
               tx_data  <= status;
               wait_cnt <= TMO_LOAD;
               wait_q   <= 1'b1;
            end
         end else if (tx_done) begin
            wait_q <= 1'b0;
         end else if (tmo) begin
            tx_to  <= 1'b1;
            wait_q <= 1'b0;
         end else begin
            wait_cnt <= wait_cnt - 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/dds_cmd_ctrl.sv
// dds_cmd_ctrl: command sequencer between the UART frame receiver and the
// DDS channel configuration registers. Latches a validated frame, decodes
// the function code, issues register writes over valid/ready, then hands a
// status byte to dds_cmd_resp. Frames arriving while busy are dropped and
// counted (saturating).
// Build macro: DDS_CMD_ECHO_EN (two-byte response: status, then func).
// Ports:
//   sys_clk, sys_rst_n          clock, async active-low reset
//   recv_done, crc_fail         frame-good / CRC-bad pulses
//   rx_byte0..rx_byte10         payload, valid with recv_done
//   cfg_valid/cfg_ready         register write handshake
//   cfg_ch, cfg_addr, cfg_wdata write target and data
//   ch_en                       per-channel output enable
//   tx_start, tx_data, tx_done  response handshake to UART transmitter
//   busy, drop_cnt, tx_to       status
//
// state   | meaning
// IDLE    | waiting for recv_done / crc_fail
// DECODE  | checking channel and function code of latched frame
// WRITE   | cfg_valid held until cfg_ready; walks addr 0..3 for SET_ALL
// RESP    | status byte being launched by dds_cmd_resp
// WAIT_TX | waiting for dds_cmd_resp to finish (tx_done or timeout)
import dds_cmd_pkg::*;

module dds_cmd_ctrl #(
   parameter int NUM_CH     = 2,
   parameter int TX_TIMEOUT = 50_000
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              recv_done,
   input  logic              crc_fail,
   input  logic [7:0]        rx_byte0,
   input  logic [7:0]        rx_byte1,
   input  logic [7:0]        rx_byte2,
   input  logic [7:0]        rx_byte3,
   input  logic [7:0]        rx_byte4,
   input  logic [7:0]        rx_byte5,
   input  logic [7:0]        rx_byte6,
   input  logic [7:0]        rx_byte7,
   input  logic [7:0]        rx_byte8,
   input  logic [7:0]        rx_byte9,
   input  logic [7:0]        rx_byte10,
   output logic              cfg_valid,
   input  logic              cfg_ready,
   output logic [3:0]        cfg_ch,
   output logic [1:0]        cfg_addr,
   output logic [31:0]       cfg_wdata,
   output logic [NUM_CH-1:0] ch_en,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_done,
   output logic              busy,
   output logic [7:0]        drop_cnt,
   output logic              tx_to
);

   state_t      state;
   logic [7:0]  func_q;
   logic [7:0]  ch_q;
   logic [31:0] freq_q;
   logic [15:0] phase_q;
   logic [15:0] amp_q;
   logic [7:0]  wave_q;
   logic        all_q;

   logic        ch_bad;
   logic        last_wr;
   logic        dec_wr;
   logic [1:0]  dec_addr;
   logic        resp_go;
   logic [7:0]  resp_status;
   logic [7:0]  resp_func;
   logic        resp_fin;

   assign ch_bad    = (ch_q >= 8'(NUM_CH));
   assign last_wr   = !all_q || (cfg_addr == ADDR_WAVE);
   // crc_fail responses echo 0x00 since no func byte was latched
   assign resp_func = (state == IDLE) ? 8'h00 : func_q;

   // Response launch is decided combinationally so tx_start lands on the
   // same edge the FSM leaves IDLE/DECODE/WRITE.
   always_comb begin
      dec_wr      = 1'b0;
      dec_addr    = ADDR_FREQ;
      resp_go     = 1'b0;
      resp_status = ST_OK;
      case (func_q)
         FN_SET_FREQ:  begin dec_wr = 1'b1; dec_addr = ADDR_FREQ;  end
         FN_SET_PHASE: begin dec_wr = 1'b1; dec_addr = ADDR_PHASE; end
         FN_SET_AMP:   begin dec_wr = 1'b1; dec_addr = ADDR_AMP;   end
         FN_SET_WAVE:  begin dec_wr = 1'b1; dec_addr = ADDR_WAVE;  end
         FN_SET_ALL:   begin dec_wr = 1'b1; dec_addr = ADDR_FREQ;  end
         default: ;
      endcase
      case (state)
         IDLE: begin
            if (crc_fail && !recv_done) begin
               resp_go     = 1'b1;
               resp_status = ST_CRC;
            end
         end
         DECODE: begin
            if (ch_bad) begin
               resp_go     = 1'b1;
               resp_status = ST_BAD_CH;
            end else if (func_q == FN_CH_ON || func_q == FN_CH_OFF) begin
               resp_go = 1'b1;
            end else if (!dec_wr) begin
               resp_go     = 1'b1;
               resp_status = ST_BAD_FN;
            end
         end
         WRITE: begin
            if (cfg_ready && last_wr) resp_go = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         func_q    <= 8'h00;
         ch_q      <= 8'h00;
         freq_q    <= 32'h0;
         phase_q   <= 16'h0;
         amp_q     <= 16'h0;
         wave_q    <= 8'h00;
         all_q     <= 1'b0;
         cfg_valid <= 1'b0;
         cfg_ch    <= 4'h0;
         cfg_addr  <= ADDR_FREQ;
         cfg_wdata <= 32'h0;
         ch_en     <= '0;
         busy      <= 1'b0;
         drop_cnt  <= 8'h00;
      end else begin
         if ((recv_done || crc_fail) && state != IDLE && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
         case (state)
            IDLE: begin
               if (recv_done) begin
                  func_q  <= rx_byte0;
                  ch_q    <= rx_byte1;
                  freq_q  <= {rx_byte2, rx_byte3, rx_byte4, rx_byte5};
                  phase_q <= {rx_byte6, rx_byte7};
                  amp_q   <= {rx_byte8, rx_byte9};
                  wave_q  <= rx_byte10;
                  busy    <= 1'b1;
                  state   <= DECODE;
               end else if (crc_fail) begin
                  busy  <= 1'b1;
                  state <= RESP;
               end
            end
            DECODE: begin
               if (!ch_bad && dec_wr) begin
                  cfg_valid <= 1'b1;
                  cfg_ch    <= ch_q[3:0];
                  cfg_addr  <= dec_addr;
                  cfg_wdata <= cfg_word(dec_addr, freq_q, phase_q, amp_q, wave_q);
                  all_q     <= (func_q == FN_SET_ALL);
                  state     <= WRITE;
               end else begin
                  if (!ch_bad && (func_q == FN_CH_ON || func_q == FN_CH_OFF)) begin
                     for (int i = 0; i < NUM_CH; i++)
                        if (ch_q == 8'(i)) ch_en[i] <= (func_q == FN_CH_ON);
                  end
                  state <= RESP;
               end
            end
            WRITE: begin
               if (cfg_ready) begin
                  if (last_wr) begin
                     cfg_valid <= 1'b0;
                     state     <= RESP;
                  end else begin
                     cfg_addr  <= cfg_addr + 2'd1;
                     cfg_wdata <= cfg_word(cfg_addr + 2'd1, freq_q, phase_q, amp_q, wave_q);
                  end
               end
            end
            RESP, WAIT_TX: begin
               // fin can already arrive in RESP if tx_done comes back instantly
               if (resp_fin) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  state <= WAIT_TX;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   dds_cmd_resp #(
      .TX_TIMEOUT (TX_TIMEOUT)
   ) u_resp (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .go        (resp_go),
      .status    (resp_status),
      .func      (resp_func),
      .tx_done   (tx_done),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_to     (tx_to),
      .fin       (resp_fin)
   );

endmodule
